// File: rtl/lut_cmp_pkg.sv
// Shared types, reset constants and the compare function for the comparator bank.
// Defines cmp_op_e (op codes 0..7), CMP_RST_OP / CMP_RST_THR, and cmp_eval().
// cmp_eval takes operands left-aligned in CMP_MAX_W bits (sample MSB at bit CMP_MAX_W-1,
// low bits zero), so one function serves every WIDTH up to CMP_MAX_W.
package lut_cmp_pkg;

    typedef enum logic [2:0] {
        CMP_LE    = 3'd0,
        CMP_LT    = 3'd1,
        CMP_GE    = 3'd2,
        CMP_GT    = 3'd3,
        CMP_EQ    = 3'd4,
        CMP_NE    = 3'd5,
        CMP_FALSE = 3'd6,
        CMP_TRUE  = 3'd7
    } cmp_op_e;

    localparam int unsigned CMP_MAX_W = 32;

    localparam cmp_op_e                CMP_RST_OP  = CMP_EQ;
    localparam logic [CMP_MAX_W-1:0]   CMP_RST_THR = '0;

    // Left alignment keeps both signed and unsigned ordering intact: the zero padding
    // sits below the LSB, so it never changes the outcome of the comparison.
    function automatic logic cmp_eval(input logic [CMP_MAX_W-1:0] a,
                                      input logic [CMP_MAX_W-1:0] thr,
                                      input cmp_op_e              op,
                                      input logic                 signed_mode);
        logic lt;
        logic eq;
        logic res;
        lt  = signed_mode ? ($signed(a) < $signed(thr)) : (a < thr);
        eq  = (a == thr);
        res = 1'b0;
        case (op)
            CMP_LE:    res = lt | eq;
            CMP_LT:    res = lt;
            CMP_GE:    res = ~lt;
            CMP_GT:    res = ~lt & ~eq;
            CMP_EQ:    res = eq;
            CMP_NE:    res = ~eq;
            CMP_FALSE: res = 1'b0;
            CMP_TRUE:  res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lut_cmp_bank_cell.sv
// One comparator channel: config registers (op, signed, threshold) plus the
// combinational evaluation of sample a against them.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cfg_we             write this channel's config (already decoded by the top)
//   cfg_op/signed/thr  new config values
//   a                  sample under test
//   hit                compare result using the currently stored config
module lut_cmp_cell
    import lut_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_op,
    input  logic             cfg_signed,
    input  logic [WIDTH-1:0] cfg_thr,
    input  logic [WIDTH-1:0] a,
    output logic             hit
);

    cmp_op_e          op_q,  op_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] thr_q, thr_d;

    logic [CMP_MAX_W-1:0] a_al;
    logic [CMP_MAX_W-1:0] thr_al;

    always_comb begin
        op_d  = op_q;
        sgn_d = sgn_q;
        thr_d = thr_q;
        if (cfg_we) begin
            op_d  = cmp_op_e'(cfg_op);
            sgn_d = cfg_signed;
            thr_d = cfg_thr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= CMP_RST_OP;
            sgn_q <= 1'b0;
            thr_q <= CMP_RST_THR[WIDTH-1:0];
        end else begin
            op_q  <= op_d;
            sgn_q <= sgn_d;
            thr_q <= thr_d;
        end
    end

    // Evaluation uses the stored config, so a same-cycle write only affects later samples.
    always_comb begin
        a_al   = CMP_MAX_W'(a)     << (CMP_MAX_W - WIDTH);
        thr_al = CMP_MAX_W'(thr_q) << (CMP_MAX_W - WIDTH);
        hit    = cmp_eval(a_al, thr_al, op_q, sgn_q);
    end

endmodule

// File: rtl/lut_cmp_bank.sv
// Bank of CHANNELS runtime-programmable comparators applied to one sample stream,
// with the result held in a one-deep valid/ready output stage.
// Optional feature: define LUT_CMP_HIT_CNT_EN for per-channel saturating hit counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/ch/op/signed/thr  channel config write (out-of-range cfg_ch is dropped)
//   in_valid/in_ready/in_data   sample input handshake
//   out_valid/out_ready/out_hit result output handshake, bit i = channel i
//   cnt_sel/cnt_val/cnt_clr  hit-counter readback and clear (zero when feature is off)
module lut_cmp_bank
    import lut_cmp_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_ch,
    input  logic [2:0]          cfg_op,
    input  logic                cfg_signed,
    input  logic [WIDTH-1:0]    cfg_thr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHANNELS-1:0] out_hit,
    input  logic [SEL_W-1:0]    cnt_sel,
    output logic [CNT_W-1:0]    cnt_val,
    input  logic                cnt_clr
);

    logic [CHANNELS-1:0] hit_vec;
    logic                accept;
    logic                consume;

    logic                out_valid_q, out_valid_d;
    logic [CHANNELS-1:0] out_hit_q,   out_hit_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
        lut_cmp_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .cfg_we     (cfg_we && (32'(cfg_ch) == i)),
            .cfg_op     (cfg_op),
            .cfg_signed (cfg_signed),
            .cfg_thr    (cfg_thr),
            .a          (in_data),
            .hit        (hit_vec[i])
        );
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_hit_d   = hit_vec;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_hit_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;

`ifdef LUT_CMP_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q [CHANNELS];
    logic [CNT_W-1:0] cnt_d [CHANNELS];

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (consume && out_hit_q[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        cnt_val = '0;
        if (32'(cnt_sel) < CHANNELS) begin
            cnt_val = cnt_q[cnt_sel];
        end
    end
`else
    logic unused_cnt_in;
    assign unused_cnt_in = ^{cnt_sel, cnt_clr};
    assign cnt_val       = '0;
`endif

endmodule

// File: tb/tb_lut_cmp_bank.sv
module tb_lut_cmp_bank;
    import lut_cmp_pkg::*;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned CHANNELS = 6;
    localparam int unsigned CNT_W    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [2:0] cfg_op = '0;
    logic       cfg_signed = 1'b0;
    logic [3:0] cfg_thr = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [5:0] out_hit;
    logic [2:0] cnt_sel = '0;
    logic [1:0] cnt_val;
    logic       cnt_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    lut_cmp_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_op     (cfg_op),
        .cfg_signed (cfg_signed),
        .cfg_thr    (cfg_thr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hit    (out_hit),
        .cnt_sel    (cnt_sel),
        .cnt_val    (cnt_val),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] ops;
        logic [5:0]  sgn;
        logic [3:0]  thr;
        logic [3:0]  a;
        logic [5:0]  exp;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [17:0] ops6(input cmp_op_e o0, input cmp_op_e o1, input cmp_op_e o2,
                                         input cmp_op_e o3, input cmp_op_e o4, input cmp_op_e o5);
        return {o5, o4, o3, o2, o1, o0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic program_ch(input logic [2:0] ch, input logic [2:0] op, input logic sgn,
                              input logic [3:0] thr);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_op     = op;
        cfg_signed = sgn;
        cfg_thr    = thr;
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic send(input logic [3:0] a);
        in_valid = 1'b1;
        in_data  = a;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{ops6(CMP_LE, CMP_LT, CMP_GE, CMP_GT, CMP_EQ, CMP_NE), 6'b000000, 4'b1010,
                    4'b1010, 6'b010101};
        vecs[1] = '{ops6(CMP_LE, CMP_LT, CMP_GE, CMP_GT, CMP_EQ, CMP_NE), 6'b000000, 4'b1010,
                    4'b0101, 6'b100011};
        // -6 vs 5: signed GE/GT false, signed LT true, unsigned GE true.
        vecs[2] = '{ops6(CMP_GE, CMP_LT, CMP_GE, CMP_GT, CMP_FALSE, CMP_TRUE), 6'b001110, 4'b0101,
                    4'b1010, 6'b100011};
        vecs[3] = '{ops6(CMP_LT, CMP_GE, CMP_LE, CMP_GT, CMP_EQ, CMP_NE), 6'b000000, 4'b0000,
                    4'b0000, 6'b010110};
        vecs[4] = '{ops6(CMP_LT, CMP_GE, CMP_LE, CMP_GT, CMP_EQ, CMP_NE), 6'b000000, 4'b0000,
                    4'b1111, 6'b101010};
        vecs[5] = '{ops6(CMP_LE, CMP_GT, CMP_LT, CMP_GE, CMP_EQ, CMP_NE), 6'b000000, 4'b1111,
                    4'b1111, 6'b011001};
        vecs[6] = '{ops6(CMP_LE, CMP_GT, CMP_LT, CMP_GE, CMP_EQ, CMP_NE), 6'b000000, 4'b1111,
                    4'b0000, 6'b100101};
        // 7 vs -8 signed.
        vecs[7] = '{ops6(CMP_LE, CMP_LT, CMP_GE, CMP_GT, CMP_EQ, CMP_NE), 6'b111111, 4'b1000,
                    4'b0111, 6'b101100};

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_hit", 32'(out_hit), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst cnt_val", 32'(cnt_val), 32'd0);

        // Defaults: EQ against 0
        send(4'b1010);
        check("dflt out_valid", 32'(out_valid), 32'd1);
        check("dflt out_hit", 32'(out_hit), 32'd0);
        step();
        check("drain out_valid", 32'(out_valid), 32'd0);
        check("drain hit hold", 32'(out_hit), 32'd0);

        // Table-driven vectors
        for (int v = 0; v < 8; v++) begin
            for (int ch = 0; ch < 6; ch++) begin
                program_ch(3'(ch), vecs[v].ops[3*ch +: 3], vecs[v].sgn[ch], vecs[v].thr);
            end
            send(vecs[v].a);
            check($sformatf("vec%0d valid", v), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d hit", v), 32'(out_hit), 32'(vecs[v].exp));
            step();
        end

        // Stall: ch i = EQ i
        for (int ch = 0; ch < 6; ch++) begin
            program_ch(3'(ch), CMP_EQ, 1'b0, 4'(ch));
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'd0;
        step();
        check("stall first hit", 32'(out_hit), 32'b000001);
        in_data = 4'd1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d hit", k), 32'(out_hit), 32'b000001);
            check($sformatf("stall%0d valid", k), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);
        step();
        check("burst hit1", 32'(out_hit), 32'b000010);
        in_data = 4'd2;
        step();
        check("burst hit2", 32'(out_hit), 32'b000100);
        in_data = 4'd3;
        step();
        check("burst hit3", 32'(out_hit), 32'b001000);
        in_valid = 1'b0;
        step();
        check("burst end valid", 32'(out_valid), 32'd0);
        check("burst end hold", 32'(out_hit), 32'b001000);

        // Config write in the same cycle as accept
        program_ch(3'd4, CMP_EQ, 1'b0, 4'b1010);
        cfg_we   = 1'b1;
        cfg_ch   = 3'd4;
        cfg_op   = CMP_EQ;
        cfg_thr  = 4'b0011;
        in_valid = 1'b1;
        in_data  = 4'b1010;
        step();
        cfg_we   = 1'b0;
        check("cfg old bit4", 32'(out_hit[4]), 32'd1);
        step();
        in_valid = 1'b0;
        check("cfg new bit4", 32'(out_hit[4]), 32'd0);

        // Out-of-range writes are dropped
        program_ch(3'd6, CMP_TRUE, 1'b0, 4'b0000);
        program_ch(3'd7, CMP_TRUE, 1'b0, 4'b0000);
        send(4'b1111);
        check("oor cfg hit", 32'(out_hit), 32'd0);

        // Reset with a pending result; config returns to defaults
        out_ready = 1'b0;
        send(4'b0000);
        check("pend valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        check("rst mid valid", 32'(out_valid), 32'd0);
        send(4'b0000);
        check("post rst hit", 32'(out_hit), 32'b111111);
        step();

`ifdef LUT_CMP_HIT_CNT_EN
        // Clear anything counted above, then saturate ch0
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        program_ch(3'd0, CMP_TRUE, 1'b0, 4'b0000);
        in_valid = 1'b1;
        in_data  = 4'b0001;
        cnt_sel  = 3'd0;
        step();
        step();
        step();
        check("cnt two", 32'(cnt_val), 32'd2);
        step();
        step();
        in_valid = 1'b0;
        step();
        check("cnt sat", 32'(cnt_val), 32'd3);
        cnt_sel = 3'd1;
        #1;
        check("cnt ch1", 32'(cnt_val), 32'd0);
        cnt_sel = 3'd7;
        #1;
        check("cnt oor", 32'(cnt_val), 32'd0);
        cnt_sel = 3'd0;
        out_ready = 1'b0;
        send(4'b0001);
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt clr wins", 32'(cnt_val), 32'd0);
        send(4'b0001);
        step();
        check("cnt after clr", 32'(cnt_val), 32'd1);
`else
        send(4'b0001);
        step();
        cnt_sel = 3'd0;
        #1;
        check("cnt tied", 32'(cnt_val), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
